// File: rtl/i2c_slave_regfile.sv
`timescale 1ns/1ps
// I2C target exposing a 2**AW x 8 register file with auto-incrementing pointer; host port reads with 1-cycle latency.
// Pad events are seen 2+FILT clk late; no clock stretching, so the target never holds off the master.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         AW         = 4,
  parameter int         FILT       = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          scl_pad_i,
  input  logic          sda_pad_i,
  output logic          sda_pad_o,
  output logic          sda_padoen_o,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  input  logic          host_we,
  output logic [7:0]    host_rdata,
  output logic          i2c_wr_valid,
  output logic [AW-1:0] i2c_wr_addr,
  output logic [7:0]    i2c_wr_data,
  output logic          busy
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] PTR       = 4'd3;
  localparam logic [3:0] PTR_ACK   = 4'd4;
  localparam logic [3:0] WDATA     = 4'd5;
  localparam logic [3:0] WDATA_ACK = 4'd6;
  localparam logic [3:0] RDATA     = 4'd7;
  localparam logic [3:0] RACK      = 4'd8;
  localparam logic [3:0] IGNORE    = 4'd9;

  localparam int CW = (FILT > 2) ? $clog2(FILT) : 1;

  logic [1:0]    scl_sync, sda_sync;
  logic [CW-1:0] scl_cnt, sda_cnt;
  logic          scl_f, sda_f, scl_d, sda_d;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]    state, bit_cnt;
  logic [7:0]    shreg, rx_byte, rd_byte;
  logic [AW-1:0] ptr;
  logic          rw, mack, sda_oe_n, commit;
  logic [7:0]    regs [2**AW];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_pad_i};
      sda_sync <= {sda_sync[0], sda_pad_i};
    end
  end

  // A new level is accepted only after FILT consecutive cycles that disagree with the current one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_f   <= 1'b1;
      scl_cnt <= '0;
    end else if (scl_sync[1] == scl_f) begin
      scl_cnt <= '0;
    end else if (scl_cnt == CW'(FILT - 1)) begin
      scl_f   <= scl_sync[1];
      scl_cnt <= '0;
    end else begin
      scl_cnt <= scl_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sda_f   <= 1'b1;
      sda_cnt <= '0;
    end else if (sda_sync[1] == sda_f) begin
      sda_cnt <= '0;
    end else if (sda_cnt == CW'(FILT - 1)) begin
      sda_f   <= sda_sync[1];
      sda_cnt <= '0;
    end else begin
      sda_cnt <= sda_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
  assign rx_byte   = {shreg[6:0], sda_f};
  assign rd_byte   = regs[ptr];
  assign commit    = scl_rise & ~start_det & ~stop_det & (state == WDATA) & (bit_cnt == 4'd7);

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = sda_oe_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_cnt      <= 4'd0;
      shreg        <= 8'h00;
      ptr          <= '0;
      rw           <= 1'b0;
      mack         <= 1'b1;
      sda_oe_n     <= 1'b1;
      busy         <= 1'b0;
      i2c_wr_valid <= 1'b0;
      i2c_wr_addr  <= '0;
      i2c_wr_data  <= 8'h00;
    end else begin
      i2c_wr_valid <= 1'b0;
      if (commit) begin
        i2c_wr_valid <= 1'b1;
        i2c_wr_addr  <= ptr;
        i2c_wr_data  <= rx_byte;
      end
      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= 4'd0;
        busy     <= 1'b0;
        sda_oe_n <= 1'b1;
      end else if (stop_det) begin
        state    <= IDLE;
        busy     <= 1'b0;
        sda_oe_n <= 1'b1;
      end else if (scl_rise) begin
        case (state)
          ADDR, PTR, WDATA: if (bit_cnt != 4'd8) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (commit) ptr <= ptr + 1'b1;
          end
          RDATA:   if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
          RACK:    mack <= sda_f;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR: if (bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            if (shreg[7:1] == SLAVE_ADDR) begin
              state    <= ADDR_ACK;
              rw       <= shreg[0];
              sda_oe_n <= 1'b0;
              busy     <= 1'b1;
            end else begin
              state <= IGNORE;
            end
          end
          PTR: if (bit_cnt == 4'd8) begin
            bit_cnt  <= 4'd0;
            ptr      <= shreg[AW-1:0];
            sda_oe_n <= 1'b0;
            state    <= PTR_ACK;
          end
          WDATA: if (bit_cnt == 4'd8) begin
            bit_cnt  <= 4'd0;
            sda_oe_n <= 1'b0;
            state    <= WDATA_ACK;
          end
          PTR_ACK, WDATA_ACK: begin
            sda_oe_n <= 1'b1;
            state    <= WDATA;
          end
          RDATA: if (bit_cnt == 4'd8) begin
            sda_oe_n <= 1'b1;
            state    <= RACK;
          end else begin
            shreg    <= {shreg[6:0], 1'b0};
            sda_oe_n <= shreg[6];
          end
          // ADDR_ACK (read) and RACK (master ACK) both start the next outgoing byte here.
          ADDR_ACK, RACK: begin
            if ((state == ADDR_ACK && !rw)) begin
              sda_oe_n <= 1'b1;
              state    <= PTR;
            end else if (state == RACK && mack) begin
              state <= IGNORE;
            end else begin
              shreg    <= rd_byte;
              sda_oe_n <= rd_byte[7];
              ptr      <= ptr + 1'b1;
              bit_cnt  <= 4'd0;
              state    <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The I2C commit is applied after the host write so it wins a same-register collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**AW; i++) regs[i] <= 8'h00;
      host_rdata <= 8'h00;
    end else begin
      if (host_we) regs[host_addr] <= host_wdata;
      if (commit)  regs[ptr] <= rx_byte;
      host_rdata <= regs[host_addr];
    end
  end

endmodule
